rf_sync_rx: RTL and testbench
=============================

// Module: rf_sync_rx
// PURPOSE
//  Parametrised RF pulse-train packet receiver; successor of the fixed 8-bit-preamble/24-bit path.
//  Syncs i_rfin, learns bit period T from the preamble, slices PKT_BITS data bits
//  (pulse in slot = 1, no pulse = 0), packs MSB-first bytes into a FWFT byte FIFO for the APB side.
//  Pulses o_pkt_rec once per packet. Sits between the RF front-end pin and the APB register block.
// PARAMETERS
//  PKT_BITS   24  data bits per packet; multiple of 8, 8..64
//  PRE_BITS   8   preamble pulses required, 3..16
//  CNT_W      20  period timer width (covers T = 1 ms at 16 MHz PCLK)
//  MIN_T      64  minimum accepted preamble interval, PCLK cycles
//  TOL_SHIFT  3   preamble interval tolerance = I_prev >> TOL_SHIFT
//  FIFO_DEPTH 4   byte FIFO entries, power of 2
// PORTS
//  i_PCLK       in   1      clock
//  i_PRESET     in   1      reset, synchronous, active-high
//  i_enable     in   1      0 = forced to HUNT, no capture
//  i_rfin       in   1      asynchronous RF pulse input
//  i_rd         in   1      pop FIFO head (ignored when empty)
//  i_clr_ovf    in   1      clears o_ovf
//  o_rx_data    out  8      FIFO head byte, 0 when empty
//  o_rx_valid   out  1      FIFO not empty
//  o_fifo_level out  clog2(FIFO_DEPTH)+1  bytes held
//  o_pkt_rec    out  1      1-cycle strobe, last bit of packet sliced
//  o_busy       out  1      state is PRE or DATA
//  o_period     out  CNT_W  T latched at preamble lock
//  o_ovf        out  1      sticky: byte dropped because FIFO full
// BEHAVIOUR
//  Reset: all outputs 0, state HUNT, FIFO empty, timer 0; reset wins over every other event.
//  Input: 2-flop sync + rising-edge detect -> "edge" lags i_rfin by 2-3 cycles; all timing uses edge.
//  Timer: +1 per cycle, saturates at all-ones; cleared on every accepted edge.
//  HUNT: edge -> PRE, pulse count = 1, timer = 0.
//  PRE: edge with timer < MIN_T -> ignored (glitch). Otherwise interval I = timer:
//   count==1: I_prev = I, count = 2. count>=2: |I - I_prev| <= I_prev>>TOL_SHIFT -> I_prev = I, count+1;
//   else restart PRE with count = 1 (this edge is new first pulse).
//   count reaches PRE_BITS -> T = I, o_period = T, DATA, bit idx 0, timer 0.
//   Timer saturation in PRE -> HUNT.
//  DATA slot rules (H = T>>1):
//   edge, timer < H        -> spurious, ignored.
//   edge, H <= timer < T+H -> bit = 1, timer = 0 (resync on pulse).
//   timer reaches T+H, no edge -> bit = 0, timer = H (slot advance without resync).
//   Edge and T+H in same cycle -> bit = 1.
//  Bits shift into byte reg MSB first; every 8th bit pushes byte to FIFO same cycle.
//  After bit PKT_BITS-1: o_pkt_rec = 1 for exactly one cycle (aligned with last push), -> HUNT.
//  Preamble is never stored. Total FIFO latency: byte visible on o_rx_data 1 cycle after push.
//  FIFO: push when full -> byte dropped, o_ovf = 1; i_clr_ovf clears (set wins if same cycle).
//   Push+pop same cycle when full -> both succeed, level unchanged. Pop when empty ignored.
//  i_enable = 0 mid-packet: abort to HUNT, partial byte discarded, no o_pkt_rec; FIFO kept.
//  Reset mid-packet: FIFO flushed, partial packet lost.
// STRUCTURE
//  rf_sync_rx_pkg.vh: state encodings (HUNT/PRE/DATA), clog2 helper, default timing constants.
//  Sub-module rx_byte_fifo (FWFT, DEPTH param, level, full/empty); slicer FSM stays in top.
// TESTING
//  T=1000 cyc, 8 pre pulses, data 24'hA5C30F, jitter 0 -> FIFO A5,C3,0F; o_pkt_rec once; o_period=1000.
//  Same with +/-10% uniform jitter per slot -> identical bytes; jitter 20% between pre pulses -> no lock.
//  Glitch 10 cyc after pulse in DATA, and pulse 30 cyc wide -> bits unaffected.
//  Two packets, no reads, FIFO_DEPTH=4 -> 4 bytes kept, 2 dropped, o_ovf=1; i_clr_ovf -> 0.
//  Assert i_PRESET at bit 13 -> all outputs 0 next cycle; following clean packet received correctly.
//  Data 24'h000000 (no data pulses) -> 3 zero bytes, o_pkt_rec at 24.5*T after last preamble edge.

Source files
------------

// File: rtl/rf_sync_rx_pkg.sv
// Shared definitions for the RF pulse-train receiver: slicer state
// encodings, default timing constants and a constant clog2 helper.
`timescale 1ns/1ps
package rf_sync_rx_pkg;

  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_PRE  = 2'd1,
    ST_DATA = 2'd2
  } rx_state_t;

  localparam int DEF_PKT_BITS   = 24;
  localparam int DEF_PRE_BITS   = 8;
  localparam int DEF_CNT_W      = 20;
  localparam int DEF_MIN_T      = 64;
  localparam int DEF_TOL_SHIFT  = 3;
  localparam int DEF_FIFO_DEPTH = 4;

  // Smallest r with 2**r >= value; usable in parameter and port expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/rf_sync_rx_byte_fifo.sv
// First-word-fall-through byte FIFO. The head entry is presented
// combinationally (0 when empty); a push becomes visible on the next cycle.
// A push while full succeeds only if a pop frees the head in the same cycle.
`timescale 1ns/1ps
module rf_sync_rx_byte_fifo
  import rf_sync_rx_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  push,
  input  logic [7:0]            push_data,
  input  logic                  pop,
  output logic [7:0]            head,
  output logic                  empty,
  output logic                  full,
  output logic [clog2(DEPTH):0] level
);

  localparam int AW = clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   level_reg;
  logic          pop_ok;
  logic          push_ok;

  assign empty   = (level_reg == '0);
  assign full    = (level_reg == (AW+1)'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign level   = level_reg;
  assign head    = empty ? 8'h00 : mem[rd_ptr_reg];

  // Storage write; contents need no reset since empty masks the head.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= push_data;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2**AW).
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level_reg <= level_reg + (AW+1)'(1);
        2'b01:   level_reg <= level_reg - (AW+1)'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/rf_sync_rx.sv
// RF pulse-train packet receiver. Synchronises the RF pin, learns the bit
// period from a run of evenly spaced preamble pulses, then slices data bits
// (pulse in slot = 1, empty slot = 0) into MSB-first bytes for a byte FIFO.
`timescale 1ns/1ps
module rf_sync_rx
  import rf_sync_rx_pkg::*;
#(
  parameter int PKT_BITS   = DEF_PKT_BITS,
  parameter int PRE_BITS   = DEF_PRE_BITS,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int MIN_T      = DEF_MIN_T,
  parameter int TOL_SHIFT  = DEF_TOL_SHIFT,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                       i_PCLK,
  input  logic                       i_PRESET,
  input  logic                       i_enable,
  input  logic                       i_rfin,
  input  logic                       i_rd,
  input  logic                       i_clr_ovf,
  output logic [7:0]                 o_rx_data,
  output logic                       o_rx_valid,
  output logic [clog2(FIFO_DEPTH):0] o_fifo_level,
  output logic                       o_pkt_rec,
  output logic                       o_busy,
  output logic [CNT_W-1:0]           o_period,
  output logic                       o_ovf
);

  localparam int PCNT_W = 5;
  localparam int BIT_W  = clog2(PKT_BITS);
  localparam logic [CNT_W-1:0] TIMER_MAX = '1;

  rx_state_t        state_reg,   state_next;
  logic [CNT_W-1:0] timer_reg,   timer_next;
  logic [PCNT_W-1:0] pcnt_reg,   pcnt_next;
  logic [CNT_W-1:0] iprev_reg,   iprev_next;
  logic [CNT_W-1:0] period_reg,  period_next;
  logic [BIT_W-1:0] bit_idx_reg, bit_idx_next;
  logic [7:0]       byte_reg,    byte_next;
  logic             pkt_rec_reg, pkt_rec_next;
  logic             ovf_reg;

  logic rfin_meta_reg, rfin_sync_reg, rfin_prev_reg;
  logic rfin_edge;

  logic [CNT_W-1:0] elapsed;
  logic [CNT_W-1:0] half_t;
  logic [CNT_W:0]   slot_end;
  logic [CNT_W-1:0] diff;
  logic [CNT_W-1:0] tol;
  logic             bit_valid;
  logic             bit_val;
  logic             push;
  logic [7:0]       push_data;
  logic             fifo_empty;
  logic             fifo_full;
  logic             fifo_drop;

  // Two-flop synchroniser plus one history flop for rising-edge detection.
  always_ff @(posedge i_PCLK) begin
    if (i_PRESET) begin
      rfin_meta_reg <= 1'b0;
      rfin_sync_reg <= 1'b0;
      rfin_prev_reg <= 1'b0;
    end else begin
      rfin_meta_reg <= i_rfin;
      rfin_sync_reg <= rfin_meta_reg;
      rfin_prev_reg <= rfin_sync_reg;
    end
  end

  assign rfin_edge = rfin_sync_reg & ~rfin_prev_reg;

  // elapsed = cycles since the last accepted edge, counting this one,
  // so an edge arriving N cycles after the previous one measures exactly N.
  assign elapsed  = (timer_reg == TIMER_MAX) ? timer_reg : timer_reg + CNT_W'(1);
  assign half_t   = period_reg >> 1;
  assign slot_end = {1'b0, period_reg} + {1'b0, half_t};
  assign diff     = (elapsed >= iprev_reg) ? (elapsed - iprev_reg) : (iprev_reg - elapsed);
  assign tol      = iprev_reg >> TOL_SHIFT;
  assign push_data = byte_next;

  // Slicer next-state: preamble lock, slot decisions and byte assembly.
  always_comb begin
    state_next   = state_reg;
    timer_next   = elapsed;
    pcnt_next    = pcnt_reg;
    iprev_next   = iprev_reg;
    period_next  = period_reg;
    bit_idx_next = bit_idx_reg;
    byte_next    = byte_reg;
    pkt_rec_next = 1'b0;
    push         = 1'b0;
    bit_valid    = 1'b0;
    bit_val      = 1'b0;

    if (!i_enable) begin
      state_next   = ST_HUNT;
      pcnt_next    = '0;
      bit_idx_next = '0;
      byte_next    = '0;
    end else begin
      case (state_reg)
        ST_HUNT: begin
          if (rfin_edge) begin
            state_next = ST_PRE;
            pcnt_next  = PCNT_W'(1);
            timer_next = '0;
          end
        end

        ST_PRE: begin
          if (rfin_edge && (elapsed >= CNT_W'(MIN_T))) begin
            timer_next = '0;
            if (pcnt_reg == PCNT_W'(1)) begin
              iprev_next = elapsed;
              pcnt_next  = PCNT_W'(2);
            end else if (diff <= tol) begin
              iprev_next = elapsed;
              if (pcnt_reg + PCNT_W'(1) == PCNT_W'(PRE_BITS)) begin
                period_next  = elapsed;
                state_next   = ST_DATA;
                bit_idx_next = '0;
                byte_next    = '0;
              end else begin
                pcnt_next = pcnt_reg + PCNT_W'(1);
              end
            end else begin
              // Interval out of tolerance: this edge starts a fresh preamble.
              pcnt_next = PCNT_W'(1);
            end
          end else if (elapsed == TIMER_MAX) begin
            state_next = ST_HUNT;
          end
        end

        ST_DATA: begin
          if (rfin_edge && (elapsed >= half_t)) begin
            bit_valid  = 1'b1;
            bit_val    = 1'b1;
            timer_next = '0;
          end else if ({1'b0, elapsed} >= slot_end) begin
            // Empty slot: move to the next slot centre without resyncing.
            bit_valid  = 1'b1;
            bit_val    = 1'b0;
            timer_next = half_t;
          end else if (elapsed == TIMER_MAX) begin
            state_next = ST_HUNT;
          end

          if (bit_valid) begin
            byte_next    = {byte_reg[6:0], bit_val};
            bit_idx_next = bit_idx_reg + BIT_W'(1);
            if (bit_idx_reg[2:0] == 3'b111) push = 1'b1;
            if (bit_idx_reg == BIT_W'(PKT_BITS - 1)) begin
              pkt_rec_next = 1'b1;
              state_next   = ST_HUNT;
            end
          end
        end

        default: state_next = ST_HUNT;
      endcase
    end
  end

  // Slicer state registers.
  always_ff @(posedge i_PCLK) begin
    if (i_PRESET) begin
      state_reg   <= ST_HUNT;
      timer_reg   <= '0;
      pcnt_reg    <= '0;
      iprev_reg   <= '0;
      period_reg  <= '0;
      bit_idx_reg <= '0;
      byte_reg    <= '0;
      pkt_rec_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      timer_reg   <= timer_next;
      pcnt_reg    <= pcnt_next;
      iprev_reg   <= iprev_next;
      period_reg  <= period_next;
      bit_idx_reg <= bit_idx_next;
      byte_reg    <= byte_next;
      pkt_rec_reg <= pkt_rec_next;
    end
  end

  // When full, the head is present, so a requested read always frees a slot.
  assign fifo_drop = push & fifo_full & ~i_rd;

  // Sticky overflow flag; a new drop outranks a clear in the same cycle.
  always_ff @(posedge i_PCLK) begin
    if (i_PRESET)       ovf_reg <= 1'b0;
    else if (fifo_drop) ovf_reg <= 1'b1;
    else if (i_clr_ovf) ovf_reg <= 1'b0;
  end

  rf_sync_rx_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (i_PCLK),
    .srst      (i_PRESET),
    .push      (push),
    .push_data (push_data),
    .pop       (i_rd),
    .head      (o_rx_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .level     (o_fifo_level)
  );

  assign o_rx_valid = ~fifo_empty;
  assign o_pkt_rec  = pkt_rec_reg;
  assign o_busy     = (state_reg != ST_HUNT);
  assign o_period   = period_reg;
  assign o_ovf      = ovf_reg;

endmodule

// File: tb/tb_rf_sync_rx.sv
// Directed bench for rf_sync_rx: packets are generated as pulse trains,
// expected bytes go into a scoreboard queue, and a monitor pops and compares
// every byte the DUT presents.
`timescale 1ns/1ps
module tb_rf_sync_rx;

  localparam int CNT_W = 12;
  localparam int LVL_W = 3;

  logic             clk = 1'b0;
  logic             i_PRESET;
  logic             i_enable;
  logic             i_rfin;
  logic             i_rd = 1'b0;
  logic             i_clr_ovf;
  logic [7:0]       o_rx_data;
  logic             o_rx_valid;
  logic [LVL_W-1:0] o_fifo_level;
  logic             o_pkt_rec;
  logic             o_busy;
  logic [CNT_W-1:0] o_period;
  logic             o_ovf;

  rf_sync_rx #(.CNT_W(CNT_W)) dut (
    .i_PCLK       (clk),
    .i_PRESET     (i_PRESET),
    .i_enable     (i_enable),
    .i_rfin       (i_rfin),
    .i_rd         (i_rd),
    .i_clr_ovf    (i_clr_ovf),
    .o_rx_data    (o_rx_data),
    .o_rx_valid   (o_rx_valid),
    .o_fifo_level (o_fifo_level),
    .o_pkt_rec    (o_pkt_rec),
    .o_busy       (o_busy),
    .o_period     (o_period),
    .o_ovf        (o_ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  bit         auto_read = 1'b1;
  int         pkt_cnt = 0;
  int         exp_pkt = 0;
  int         pkt_cyc = 0;
  int         last_pre_cyc = 0;
  logic       pkt_prev = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: counts o_pkt_rec strobes and pops/compares FIFO bytes.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      i_rd = 1'b0;
      if (o_pkt_rec) begin
        check("pkt_rec_one_cycle", pkt_prev, 0);
        pkt_cnt++;
        pkt_cyc = cyc;
        $display("pkt_rec strobe at cycle %0d", cyc);
      end
      pkt_prev = o_pkt_rec;
      if (auto_read && o_rx_valid && !i_PRESET) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %02h expected none", o_rx_data);
        end else begin
          e = exp_q.pop_front();
          $display("rx byte %02h expected %02h", o_rx_data, e);
          check("rx_byte", o_rx_data, e);
        end
        i_rd = 1'b1;
      end
    end
  end

  task automatic wait_to(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic pulse(input int width);
    i_rfin = 1'b1;
    repeat (width) @(negedge clk);
    i_rfin = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_rx_data"}, o_rx_data, 0);
    check({tag, "_rx_valid"}, o_rx_valid, 0);
    check({tag, "_level"}, o_fifo_level, 0);
    check({tag, "_pkt_rec"}, o_pkt_rec, 0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_period"}, o_period, 0);
    check({tag, "_ovf"}, o_ovf, 0);
  endtask

  // One packet: 8 preamble pulses T apart, then 24 data slots.
  // keep: bytes expected to survive into the FIFO; abort_bit >= 0 resets there.
  task automatic send_pkt(input int t, input logic [23:0] data, input int jit,
                          input bit glitch, input int abort_bit, input int keep);
    int start, target, s;
    bit wide;
    for (int b = 0; b < 3; b++)
      if (b < keep && (abort_bit < 0 || b * 8 + 7 < abort_bit))
        exp_q.push_back(data[23 - 8 * b -: 8]);
    @(negedge clk);
    start = cyc;
    for (int p = 0; p < 8; p++) begin
      wait_to(start + p * t);
      if (p == 7) last_pre_cyc = cyc;
      pulse(4);
    end
    for (int k = 0; k < 24; k++) begin
      target = last_pre_cyc + (k + 1) * t;
      if (jit > 0) target += int'($urandom_range(2 * jit)) - jit;
      if (k == abort_bit) begin
        wait_to(target);
        i_PRESET = 1'b1;
        @(negedge clk);
        check_zero_outputs("midpkt_reset");
        i_PRESET = 1'b0;
        return;
      end
      if (data[23 - k]) begin
        wait_to(target);
        s = cyc;
        wide = glitch && (k % 3 == 0);
        pulse(wide ? 30 : 4);
        if (glitch && !wide) begin
          wait_to(s + 10);
          pulse(2);
        end
      end
    end
    wait_to(last_pre_cyc + 25 * t + 10);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    int t;
    i_PRESET  = 1'b1;
    i_enable  = 1'b1;
    i_rfin    = 1'b0;
    i_clr_ovf = 1'b0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    i_PRESET = 1'b0;
    repeat (5) @(negedge clk);

    // Clean packet, T = 300
    send_pkt(300, 24'hA5C30F, 0, 1'b0, -1, 3);
    exp_pkt++;
    check("clean_period", o_period, 300);
    check("clean_pkt_cnt", pkt_cnt, exp_pkt);
    drain("clean");

    // Same data with +/-10% slot jitter, T = 200
    send_pkt(200, 24'hA5C30F, 20, 1'b0, -1, 3);
    exp_pkt++;
    check("jitter_period", o_period, 200);
    check("jitter_pkt_cnt", pkt_cnt, exp_pkt);
    drain("jitter");

    // Preamble with 20% interval swings never locks, then times out
    @(negedge clk);
    t = cyc;
    for (int p = 0; p < 10; p++) begin
      wait_to(t);
      pulse(4);
      t += (p % 2 == 0) ? 200 : 240;
    end
    repeat (20) @(negedge clk);
    check("nolock_busy_in_pre", o_busy, 1);
    repeat (4300) @(negedge clk);
    check("nolock_timeout_hunt", o_busy, 0);
    check("nolock_pkt_cnt", pkt_cnt, exp_pkt);
    check("nolock_period_kept", o_period, 200);
    check("nolock_fifo_empty", o_rx_valid, 0);

    // Glitches 10 cycles after pulses and 30-cycle-wide pulses
    send_pkt(200, 24'h5A3C96, 0, 1'b1, -1, 3);
    exp_pkt++;
    check("glitch_pkt_cnt", pkt_cnt, exp_pkt);
    drain("glitch");

    // Two packets without reads: 4 bytes kept, 2 dropped
    auto_read = 1'b0;
    send_pkt(200, 24'hA5C30F, 0, 1'b0, -1, 3);
    send_pkt(200, 24'h123456, 0, 1'b0, -1, 1);
    exp_pkt += 2;
    check("ovf_level", o_fifo_level, 4);
    check("ovf_set", o_ovf, 1);
    check("ovf_pkt_cnt", pkt_cnt, exp_pkt);
    i_clr_ovf = 1'b1;
    @(negedge clk);
    i_clr_ovf = 1'b0;
    check("ovf_cleared", o_ovf, 0);
    auto_read = 1'b1;
    drain("ovf");
    check("ovf_level_drained", o_fifo_level, 0);

    // Reset asserted at data bit 13, then a clean packet
    send_pkt(200, 24'hC0FFEE, 0, 1'b0, 13, 3);
    repeat (5) @(negedge clk);
    check("abort_pkt_cnt", pkt_cnt, exp_pkt);
    send_pkt(200, 24'h3C5AA5, 0, 1'b0, -1, 3);
    exp_pkt++;
    check("after_reset_period", o_period, 200);
    check("after_reset_pkt_cnt", pkt_cnt, exp_pkt);
    drain("after_reset");

    // All-zero data: strobe 24.5*T after the last preamble edge
    // (+2 synchroniser cycles, +1 output register)
    send_pkt(200, 24'h000000, 0, 1'b0, -1, 3);
    exp_pkt++;
    check("zero_pkt_cnt", pkt_cnt, exp_pkt);
    check("zero_pkt_latency", pkt_cyc - last_pre_cyc, 24 * 200 + 100 + 3);
    drain("zero");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard bound on run time.
  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
